// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port between ALU (port 0) and load (port 1) writeback; accept-to-RegWrite is 1 cycle.
// A full buffer that is not granted holds its Ready low. Optional contention counter behind REGFILE_WRARB_STATS_EN.
module regfile_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic [ADDRW-1:0] Req0Addr,
    input  logic [WIDTH-1:0] Req0Data,
    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic [ADDRW-1:0] Req1Addr,
    input  logic [WIDTH-1:0] Req1Data,
    output logic             RegWrite,
    output logic [ADDRW-1:0] WriteRegister,
    output logic [WIDTH-1:0] WriteData,
    output logic [15:0]      ConflictCount
);

    logic             full0, full1;
    logic [ADDRW-1:0] addr0, addr1;
    logic [WIDTH-1:0] data0, data1;
    logic             older1;   // port 1 was loaded strictly earlier than port 0
    logic             rr;       // favored port for different-address contention
    logic             grant0, grant1;
    logic             contended;
    logic             load0, load1;

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        contended = 1'b0;
        if (full0 && full1) begin
            // Same destination: oldest first so the newest value lands last.
            if (addr0 == addr1) begin
                grant1 = older1;
                grant0 = !older1;
            end else begin
                contended = 1'b1;
                grant1    = rr;
                grant0    = !rr;
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    assign Req0Ready = !Reset && (!full0 || grant0);
    assign Req1Ready = !Reset && (!full1 || grant1);

    // Writes to register 0 are accepted and dropped.
    assign load0 = Req0Valid && Req0Ready && (Req0Addr != '0);
    assign load1 = Req1Valid && Req1Ready && (Req1Addr != '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            full0  <= 1'b0;
            full1  <= 1'b0;
            addr0  <= '0;
            addr1  <= '0;
            data0  <= '0;
            data1  <= '0;
            older1 <= 1'b0;
            rr     <= 1'b0;
        end else begin
            full0 <= load0 || (full0 && !grant0);
            full1 <= load1 || (full1 && !grant1);
            if (load0) begin
                addr0 <= Req0Addr;
                data0 <= Req0Data;
            end
            if (load1) begin
                addr1 <= Req1Addr;
                data1 <= Req1Data;
            end
            // Same-edge loads tie-break to port 0.
            if (load0 && load1)
                older1 <= 1'b0;
            else if (load0)
                older1 <= 1'b1;
            else if (load1)
                older1 <= 1'b0;
            if (contended)
                rr <= !rr;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= grant0 || grant1;
            if (grant0) begin
                WriteRegister <= addr0;
                WriteData     <= data0;
            end else if (grant1) begin
                WriteRegister <= addr1;
                WriteData     <= data1;
            end
        end
    end

`ifdef REGFILE_WRARB_STATS_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            conflict_cnt <= '0;
        else if (full0 && full1 && (conflict_cnt != 16'hFFFF))
            conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign ConflictCount = conflict_cnt;
`else
    assign ConflictCount = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a timestamp-based buffer model.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Reset;
    logic        in_vld  [2];
    logic [4:0]  in_addr [2];
    logic [31:0] in_data [2];
    logic        Req0Ready, Req1Ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [15:0] ConflictCount;

    regfile_write_arbiter #(.WIDTH(32), .ADDRW(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req0Valid     (in_vld[0]),
        .Req0Ready     (Req0Ready),
        .Req0Addr      (in_addr[0]),
        .Req0Data      (in_data[0]),
        .Req1Valid     (in_vld[1]),
        .Req1Ready     (Req1Ready),
        .Req1Addr      (in_addr[1]),
        .Req1Data      (in_data[1]),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ConflictCount (ConflictCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffers stamped with the cycle they were loaded in.
    bit          m_full [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    int          m_t    [2];
    int          m_rr;
    int          cyc;
    bit          exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    int          exp_cnt;
    logic [31:0] dut_rf [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_full[n] = 1'b0;
            m_addr[n] = '0;
            m_data[n] = '0;
            m_t[n]    = 0;
        end
        m_rr    = 0;
        exp_we  = 1'b0;
        exp_wa  = '0;
        exp_wd  = '0;
        exp_cnt = 0;
    endtask

    // Called just after a rising edge with inputs already driven; returns just after the next one.
    task automatic step();
        int g;
        bit rdy [2];
        bit ld  [2];
        bit both;
        @(negedge Clk);
        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1])
                g = (m_t[1] < m_t[0]) ? 1 : 0;
            else begin
                g    = m_rr;
                m_rr = 1 - m_rr;
            end
        end else if (m_full[0])
            g = 0;
        else if (m_full[1])
            g = 1;
        for (int n = 0; n < 2; n++) begin
            rdy[n] = !m_full[n] || (g == n);
            ld[n]  = in_vld[n] && rdy[n] && (in_addr[n] != 5'd0);
        end
        both = m_full[0] && m_full[1];
        check_eq("ready0", {31'd0, Req0Ready}, {31'd0, rdy[0]});
        check_eq("ready1", {31'd0, Req1Ready}, {31'd0, rdy[1]});
        @(posedge Clk);
        #1;
        cyc++;
`ifdef REGFILE_WRARB_STATS_EN
        if (both && exp_cnt != 16'hFFFF)
            exp_cnt++;
`else
        if (both)
            exp_cnt = 0;
`endif
        exp_we = (g >= 0);
        if (g >= 0) begin
            exp_wa    = m_addr[g];
            exp_wd    = m_data[g];
            m_full[g] = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            if (ld[n]) begin
                m_full[n] = 1'b1;
                m_addr[n] = in_addr[n];
                m_data[n] = in_data[n];
                m_t[n]    = cyc;
            end
        end
        check_eq("regwrite", {31'd0, RegWrite}, {31'd0, exp_we});
        check_eq("wreg", {27'd0, WriteRegister}, {27'd0, exp_wa});
        check_eq("wdata", WriteData, exp_wd);
        check_eq("conflicts", {16'd0, ConflictCount}, exp_cnt);
        if (RegWrite)
            dut_rf[WriteRegister] = WriteData;
    endtask

    task automatic drive(input int n, input logic v, input logic [4:0] a, input logic [31:0] d);
        in_vld[n]  = v;
        in_addr[n] = a;
        in_data[n] = d;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        drive(0, 1'b0, 5'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0);
        Reset = 1'b1;
        model_reset();
        #1;
        check_eq("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check_eq("rst_wreg", {27'd0, WriteRegister}, 32'd0);
        check_eq("rst_wdata", WriteData, 32'd0);
        check_eq("rst_ready0", {31'd0, Req0Ready}, 32'd0);
        check_eq("rst_ready1", {31'd0, Req1Ready}, 32'd0);
        check_eq("rst_conflicts", {16'd0, ConflictCount}, 32'd0);
        #7;
        Reset = 1'b0;

        // Single write on port 0.
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        drive(0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        check_eq("single_rf5", dut_rf[5], 32'hDEADBEEF);

        // Register 0 writes are swallowed.
        drive(1, 1'b1, 5'd0, 32'h1234);
        step();
        drive(1, 1'b0, 5'd0, 32'd0);
        repeat (3) step();

        // Different-address contention alternates 3,7.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b1, 5'd3, $urandom);
            drive(1, 1'b1, 5'd7, $urandom);
            step();
        end
        drive(0, 1'b0, 5'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0);
        repeat (3) step();

        // Same address: port 1 first, then port 0.
        drive(1, 1'b1, 5'd9, 32'hA);
        step();
        drive(1, 1'b0, 5'd0, 32'd0);
        drive(0, 1'b1, 5'd9, 32'hB);
        step();
        drive(0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        check_eq("order_rf9", dut_rf[9], 32'hB);

        // Same address, same edge: port 0 commits first.
        drive(0, 1'b1, 5'd9, 32'hC);
        drive(1, 1'b1, 5'd9, 32'hD);
        step();
        drive(0, 1'b0, 5'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        check_eq("tie_rf9", dut_rf[9], 32'hD);

        // Asynchronous reset mid-operation.
        drive(0, 1'b1, 5'd3, 32'h33);
        drive(1, 1'b1, 5'd7, 32'h77);
        repeat (3) step();
        check_eq("pre_rst_regwrite", {31'd0, RegWrite}, 32'd1);
        drive(0, 1'b0, 5'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0);
        #1 Reset = 1'b1;
        #1;
        check_eq("arst_regwrite", {31'd0, RegWrite}, 32'd0);
        check_eq("arst_wreg", {27'd0, WriteRegister}, 32'd0);
        check_eq("arst_wdata", WriteData, 32'd0);
        check_eq("arst_ready0", {31'd0, Req0Ready}, 32'd0);
        check_eq("arst_ready1", {31'd0, Req1Ready}, 32'd0);
        check_eq("arst_conflicts", {16'd0, ConflictCount}, 32'd0);
        #1 Reset = 1'b0;
        model_reset();
        repeat (2) step();
        drive(0, 1'b1, 5'd3, 32'h303);
        drive(1, 1'b1, 5'd7, 32'h707);
        repeat (2) step();
        check_eq("post_rst_first", {27'd0, WriteRegister}, 32'd3);
        drive(0, 1'b0, 5'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0);
        repeat (3) step();

        // Random traffic with a small address pool to force collisions and zero writes.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++)
                drive(n, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom);
            step();
        end

`ifdef REGFILE_WRARB_STATS_EN
        for (int i = 0; i < 70000; i++) begin
            drive(0, 1'b1, 5'd3, $urandom);
            drive(1, 1'b1, 5'd7, $urandom);
            step();
        end
        check_eq("saturated", {16'd0, ConflictCount}, 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
